// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        S_LEN,
        S_HI,
        S_LO,
        S_CHK,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_t;

    // A length byte of zero stands for a full 256-word image.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    import loader_pkg::*;

    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;

    // Host side: produces the byte stream and observes the memory writes.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side: consumes the byte stream and drives the memory write port.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/xor_acc.sv
// 8-bit running XOR used to verify the image checksum.
module xor_acc (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic       xor_en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    // Load replaces the running value; xor_en folds the byte in.
    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = din;
        end else if (xor_en) begin
            acc_d = acc_q ^ din;
        end
    end

    // Accumulator register, cleared synchronously.
    always_ff @(posedge clk) begin
        if (clear) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: assembles 16-bit words from a byte stream, writes them to
// instruction memory, checks an XOR checksum and then releases the CPU.
//
//   state  | meaning
//   -------+----------------------------------------------
//   S_LEN  | waiting for the length byte
//   S_HI   | waiting for the high byte of a word
//   S_LO   | waiting for the low byte of a word
//   S_CHK  | waiting for the checksum byte
//   S_HOLD | checksum good, counting down before release
//   S_RUN  | CPU released (sticky until reload/reset)
//   S_ERR  | checksum mismatch (sticky until reload/reset)
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int HOLD_CYC = 4    // legal range 1..15
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus,
    input  logic          reload,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);

    state_t              state_q, state_d;
    logic [8:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          hi_q, hi_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          hold_q, hold_d;

    logic                in_ready;
    logic                accept;
    logic                chk_ok;
    logic                acc_load;
    logic                acc_xor;
    logic [7:0]          acc_val;

    assign accept = bus.in_valid & in_ready;
    assign chk_ok = (bus.in_data == acc_val);

    xor_acc u_xor_acc (
        .clk    (clk),
        .clear  (reset),
        .load   (acc_load),
        .xor_en (acc_xor),
        .din    (bus.in_data),
        .acc    (acc_val)
    );

    // State, counters and write register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LEN;
            cnt_q   <= '0;
            addr_q  <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN:   if (accept) state_d = S_HI;
            S_HI:    if (accept) state_d = S_LO;
            S_LO:    if (accept) state_d = (cnt_q == 9'd1) ? S_CHK : S_HI;
            S_CHK:   if (accept) state_d = chk_ok ? S_HOLD : S_ERR;
            S_HOLD:  if (hold_q == 4'd1) state_d = S_RUN;
            S_RUN,
            S_ERR:   if (reload) state_d = S_LEN;
            default: state_d = S_LEN;
        endcase
    end

    // Word assembly, address/count bookkeeping and the one-cycle write pulse.
    always_comb begin
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        hi_d     = hi_q;
        we_d     = 1'b0;
        maddr_d  = maddr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        acc_load = 1'b0;
        acc_xor  = 1'b0;
        case (state_q)
            S_LEN: begin
                if (accept) begin
                    cnt_d    = len_to_count(bus.in_data);
                    addr_d   = '0;
                    acc_load = 1'b1;
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = bus.in_data;
                    acc_xor = 1'b1;
                end
            end
            S_LO: begin
                if (accept) begin
                    acc_xor = 1'b1;
                    we_d    = 1'b1;
                    maddr_d = addr_q;
                    wdata_d = {hi_q, bus.in_data};
                    // Wraps 255 -> 0 only on a 256-word image, which ends here.
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = cnt_q - 9'd1;
                end
            end
            S_CHK: begin
                if (accept && chk_ok) begin
                    hold_d = 4'(HOLD_CYC);
                end
            end
            S_HOLD: begin
                hold_d = hold_q - 4'd1;
            end
            default: ;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        in_ready = (state_q == S_LEN) || (state_q == S_HI) ||
                   (state_q == S_LO)  || (state_q == S_CHK);
        cpu_rst  = (state_q != S_RUN);
        done     = (state_q == S_RUN);
        err      = (state_q == S_ERR);
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven loads, hand-written
// corner sequences and random loads checked against a stream model.
module tb_prog_loader;

    localparam int HOLD_CYC = 4;

    logic clk = 1'b0;
    logic reset;
    logic reload;
    logic cpu_rst;
    logic done;
    logic err;

    prog_loader_if #(.ADDR_W(8)) bus ();

    prog_loader #(.ADDR_W(8), .HOLD_CYC(HOLD_CYC)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .reload  (reload),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] wbuf [256];
    logic [7:0]  wr_addr [$];
    logic [15:0] wr_data [$];

    typedef struct {
        int          n;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [7:0]  chk;
        int          maxgap;
        bit          exp_err;
    } vec_t;

    vec_t vecs [6];

    // Record every write pulse the loader issues.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one byte after a number of idle cycles; returns at the negedge
    // following the edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    // Reference checksum: LEN byte XOR every data byte of the image.
    function automatic logic [7:0] stream_xor(input int n);
        logic [7:0] x;
        x = 8'(n);
        for (int i = 0; i < n; i++) x = x ^ wbuf[i][15:8] ^ wbuf[i][7:0];
        return x;
    endfunction

    // Stream wbuf[0..n-1] with the given checksum and check the outcome.
    task automatic do_load(input int n, input logic [7:0] chk, input int maxgap,
                           input bit exp_err, input bit rl_hi);
        int cyc;
        int bad;
        wr_addr.delete();
        wr_data.delete();
        bad = 0;
        send_byte(8'(n), int'($urandom_range(0, maxgap)));
        if (rl_hi) begin
            reload = 1'b1;
            @(negedge clk);
            reload = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i][15:8], int'($urandom_range(0, maxgap)));
            send_byte(wbuf[i][7:0], int'($urandom_range(0, maxgap)));
            if (!(bus.mem_we === 1'b1 && bus.mem_addr === 8'(i) && bus.mem_wdata === wbuf[i]))
                bad++;
        end
        send_byte(chk, int'($urandom_range(0, maxgap)));
        if (exp_err) begin
            check("err_set", err, 1);
            check("err_cpu_rst", cpu_rst, 1);
            check("err_ready", bus.in_ready, 0);
            check("err_done", done, 0);
            repeat (3) @(negedge clk);
            check("err_sticky", err, 1);
        end else begin
            cyc = 1;
            while (cpu_rst === 1'b1 && cyc < 64) begin
                @(negedge clk);
                cyc++;
            end
            check("release_cycles", cyc, HOLD_CYC + 1);
            check("run_done", done, 1);
            check("run_err", err, 0);
            check("run_ready", bus.in_ready, 0);
            repeat (2) @(negedge clk);
            check("run_sticky", cpu_rst, 0);
        end
        check("we_after_lo", bad, 0);
        check("write_count", wr_addr.size(), n);
        bad = 0;
        for (int i = 0; i < n && i < wr_addr.size(); i++)
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== wbuf[i]) bad++;
        check("write_content", bad, 0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_cpu_rst", cpu_rst, 1);
        check("reload_done", done, 0);
        check("reload_err", err, 0);
        check("reload_ready", bus.in_ready, 1);
    endtask

    initial begin
        logic [7:0] x;
        bit         bad_chk;
        int         n;

        // 02,12,34,AB,CD -> 0x42 ; 01,AA,55 -> 0xFE ; 02,00,00,FF,FF -> 0x02 ; 01,01,02 -> 0x02
        vecs[0] = '{2, 16'h1234, 16'hABCD, 8'h42, 0, 1'b0};
        vecs[1] = '{2, 16'h1234, 16'hABCD, 8'h41, 0, 1'b1};
        vecs[2] = '{1, 16'hAA55, 16'h0000, 8'hFE, 3, 1'b0};
        vecs[3] = '{1, 16'hAA55, 16'h0000, 8'hFF, 0, 1'b1};
        vecs[4] = '{2, 16'h0000, 16'hFFFF, 8'h02, 1, 1'b0};
        vecs[5] = '{1, 16'h0102, 16'h0000, 8'h03, 2, 1'b1};

        reset        = 1'b1;
        reload       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_ready", bus.in_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            wbuf[0] = vecs[v].w0;
            wbuf[1] = vecs[v].w1;
            do_load(vecs[v].n, vecs[v].chk, vecs[v].maxgap, vecs[v].exp_err, 1'b0);
            pulse_reload();
        end

        // Full 256-word image announced with LEN = 0, stream held valid.
        for (int i = 0; i < 256; i++) wbuf[i] = 16'($urandom);
        do_load(256, stream_xor(256), 0, 1'b0, 1'b0);
        pulse_reload();

        // Reset arriving together with the LO byte cancels the write.
        send_byte(8'h01, 0);
        send_byte(8'h5A, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        reset        = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        check("rstlo_mem_we", bus.mem_we, 0);
        check("rstlo_ready", bus.in_ready, 1);
        check("rstlo_cpu_rst", cpu_rst, 1);
        @(negedge clk);
        check("rstlo_mem_we2", bus.mem_we, 0);
        wbuf[0] = 16'h3C96;
        do_load(1, stream_xor(1), 1, 1'b0, 1'b0);
        pulse_reload();

        // Reload while waiting for a HI byte is ignored.
        wbuf[0] = 16'hBEEF;
        wbuf[1] = 16'h0F1E;
        do_load(2, stream_xor(2), 0, 1'b0, 1'b1);
        pulse_reload();

        // Random images, random gaps, occasional corrupted checksum.
        for (int r = 0; r < 15; r++) begin
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
            bad_chk = ($urandom_range(0, 3) == 0);
            x = stream_xor(n);
            if (bad_chk) x = x ^ 8'($urandom_range(1, 255));
            do_load(n, x, int'($urandom_range(0, 3)), bad_chk, 1'b0);
            pulse_reload();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
